// File: rtl/cache_pkg.sv
// cache_pkg: shared definitions for the line-fetch cache family.
//   state_t    - controller states (IDLE, LOOKUP, MISS_REQ, MISS_WAIT, RESP)
//   ADDR_W     - byte address width
//   off_bits / idx_bits / tag_bits / way_bits - field widths from geometry
//   line_base  - clears the in-line offset bits of a byte address
package cache_pkg;

   localparam int unsigned ADDR_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      MISS_REQ,
      MISS_WAIT,
      RESP
   } state_t;

   function automatic int unsigned off_bits(input int unsigned width);
      return $clog2(width / 8);
   endfunction

   function automatic int unsigned idx_bits(input int unsigned depth);
      return $clog2(depth);
   endfunction

   function automatic int unsigned tag_bits(input int unsigned width, input int unsigned depth);
      return ADDR_W - off_bits(width) - idx_bits(depth);
   endfunction

   // A direct-mapped build still needs a 1-bit way number.
   function automatic int unsigned way_bits(input int unsigned ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

   function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr,
                                                   input int unsigned ob);
      return (addr >> ob) << ob;
   endfunction

endpackage

// File: rtl/cache_way.sv
// cache_way: one way of the set-associative cache.
//   clk, reset    - clock, synchronous active-low reset (clears valid bits)
//   inv_all       - clear every valid bit
//   lookup_index  - set to inspect; lookup_tag - tag to compare
//   match         - valid entry at lookup_index holds lookup_tag
//   valid_at      - valid bit at lookup_index
//   rd_line       - line stored at lookup_index
//   wr_en, wr_index, wr_tag, wr_line - install a line and mark it valid
module cache_way
   import cache_pkg::*;
#(
   parameter int unsigned WIDTH = 128,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TAG_W = 26,
   parameter int unsigned IB    = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inv_all,
   input  logic [IB-1:0]    lookup_index,
   input  logic [TAG_W-1:0] lookup_tag,
   output logic             match,
   output logic             valid_at,
   output logic [WIDTH-1:0] rd_line,
   input  logic             wr_en,
   input  logic [IB-1:0]    wr_index,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic [WIDTH-1:0] wr_line
);

   logic [DEPTH-1:0] valid;
   logic [TAG_W-1:0] tags  [DEPTH];
   logic [WIDTH-1:0] lines [DEPTH];

   always_ff @(posedge clk) begin
      if (!reset || inv_all) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_index] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tags[wr_index]  <= wr_tag;
         lines[wr_index] <= wr_line;
      end
   end

   always_comb begin
      valid_at = valid[lookup_index];
      match    = valid_at && (tags[lookup_index] == lookup_tag);
      rd_line  = lines[lookup_index];
   end

endmodule

// File: rtl/assoc_cache.sv
// assoc_cache: N-way set-associative read-only line cache with miss handling.
//   clk, reset                  - clock, synchronous active-low reset
//   req_valid/req_addr/req_ready - line-read request handshake
//   flush                       - invalidate all lines (honoured in IDLE only)
//   resp_valid/resp_data/resp_hit - one-cycle response pulse with the line
//   mem_req_valid/addr/ready    - line fetch to next level
//   mem_resp_valid/mem_resp_data - fill data
//   hit_count, miss_count       - saturating event counters
module assoc_cache
   import cache_pkg::*;
#(
   parameter int unsigned WIDTH = 128,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WAYS  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic [31:0]       req_addr,
   output logic              req_ready,
   input  logic              flush,
   output logic              resp_valid,
   output logic [WIDTH-1:0]  resp_data,
   output logic              resp_hit,
   output logic              mem_req_valid,
   output logic [31:0]       mem_req_addr,
   input  logic              mem_req_ready,
   input  logic              mem_resp_valid,
   input  logic [WIDTH-1:0]  mem_resp_data,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
);

   localparam int unsigned OB = off_bits(WIDTH);
   localparam int unsigned IB = idx_bits(DEPTH);
   localparam int unsigned TW = tag_bits(WIDTH, DEPTH);
   localparam int unsigned WB = way_bits(WAYS);

   state_t state, state_next;

   logic [31:0]      addr_q;
   logic [IB-1:0]    idx;
   logic [TW-1:0]    tag;
   logic [WAYS-1:0]  match, valid_at, way_wr;
   logic [WIDTH-1:0] rd_line [WAYS];
   logic [WIDTH-1:0] hit_line;
   logic             hit, all_valid, fill, inv_all, found;
   logic [WB-1:0]    victim;
   logic [WB-1:0]    rr_ptr [DEPTH];
   logic [31:0]      hit_cnt, miss_cnt;

   assign idx        = addr_q[OB+IB-1:OB];
   assign tag        = addr_q[31:OB+IB];
   assign req_ready  = (state == IDLE) && !flush;
   assign inv_all    = (state == IDLE) && flush;
   assign fill       = reset && (state == MISS_WAIT) && mem_resp_valid;
   assign hit_count  = hit_cnt;
   assign miss_count = miss_cnt;

   for (genvar g = 0; g < WAYS; g++) begin : g_way
      assign way_wr[g] = fill && (victim == WB'(g));

      cache_way #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH),
         .TAG_W (TW),
         .IB    (IB)
      ) u_way (
         .clk          (clk),
         .reset        (reset),
         .inv_all      (inv_all),
         .lookup_index (idx),
         .lookup_tag   (tag),
         .match        (match[g]),
         .valid_at     (valid_at[g]),
         .rd_line      (rd_line[g]),
         .wr_en        (way_wr[g]),
         .wr_index     (idx),
         .wr_tag       (tag),
         .wr_line      (mem_resp_data)
      );
   end

   // At most one way matches, so an OR of the gated lines is the hit line.
   always_comb begin
      hit_line = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (match[w]) hit_line = hit_line | rd_line[w];
      end
      hit = |match;
   end

   // Lowest invalid way first; round-robin pointer only when the set is full.
   always_comb begin
      all_valid = &valid_at;
      victim    = rr_ptr[idx];
      found     = 1'b0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (!found && !valid_at[w]) begin
            victim = WB'(w);
            found  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:      if (!flush && req_valid) state_next = LOOKUP;
         LOOKUP:    state_next = hit ? RESP : MISS_REQ;
         MISS_REQ:  if (mem_req_valid && mem_req_ready) state_next = MISS_WAIT;
         MISS_WAIT: if (mem_resp_valid) state_next = RESP;
         RESP:      state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   // mem_req_valid rises one cycle into MISS_REQ, and a hit's line is latched
   // in LOOKUP but pulsed on leaving RESP, while a fill pulses on entry to
   // RESP; resp_hit tells RESP which of the two it is finishing.
   always_ff @(posedge clk) begin
      if (!reset) begin
         addr_q        <= '0;
         resp_valid    <= 1'b0;
         resp_hit      <= 1'b0;
         resp_data     <= '0;
         mem_req_valid <= 1'b0;
         mem_req_addr  <= '0;
         hit_cnt       <= '0;
         miss_cnt      <= '0;
         for (int unsigned s = 0; s < DEPTH; s++) rr_ptr[s] <= '0;
      end else begin
         resp_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req_valid && req_ready) addr_q <= line_base(req_addr, OB);
            end
            LOOKUP: begin
               if (hit) begin
                  resp_data <= hit_line;
                  resp_hit  <= 1'b1;
                  if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
               end else begin
                  resp_hit     <= 1'b0;
                  mem_req_addr <= addr_q;
                  if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
               end
            end
            MISS_REQ: begin
               if (!mem_req_valid)    mem_req_valid <= 1'b1;
               else if (mem_req_ready) mem_req_valid <= 1'b0;
            end
            MISS_WAIT: begin
               if (mem_resp_valid) begin
                  resp_data  <= mem_resp_data;
                  resp_hit   <= 1'b0;
                  resp_valid <= 1'b1;
                  if (all_valid && WAYS > 1) rr_ptr[idx] <= rr_ptr[idx] + 1'b1;
               end
            end
            RESP: begin
               resp_valid <= resp_hit;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/assoc_cache.md
# assoc_cache

Parametrised N-way set-associative read-only cache with integrated miss handling; the next generation of the line-fetch cache in the fetch/load path. Accepts line-read requests through a valid/ready handshake, returns whole lines, and on a miss fetches the line from the next memory level, installs it in a victim way and returns it. It adds victim selection, flush and hit/miss counters.

## Interface
- WIDTH, 128: bits per cache line; power of two, at least 32.
- DEPTH, 4: sets per way; power of two, at least 2.
- WAYS, 2: associativity; power of two, at least 1.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising edge of clk.
- req_valid  in  1  request present.
- req_addr  in  32  byte address of the request.
- req_ready  out  1  request accepted on an edge where req_valid && req_ready.
- flush  in  1  invalidate all lines.
- resp_valid  out  1  one-cycle pulse: resp_data is valid.
- resp_data  out  WIDTH  line containing req_addr.
- resp_hit  out  1  with resp_valid: 1 = hit, 0 = filled from memory.
- mem_req_valid  out  1  line fetch request.
- mem_req_addr  out  32  line-aligned fetch address; offset bits are 0.
- mem_req_ready  in  1  memory accepts the fetch.
- mem_resp_valid  in  1  fill data present.
- mem_resp_data  in  WIDTH  fill line.
- hit_count, miss_count  out  32  saturating event counters.

## Operation
- Address split: OB = clog2(WIDTH/8) offset bits; IB = clog2(DEPTH) index bits = addr[OB+IB-1:OB]; tag = addr[31:OB+IB].
- The FSM has five states: IDLE, LOOKUP, MISS_REQ, MISS_WAIT, RESP.
  - req_ready = (state==IDLE) && !flush.
  - IDLE: on handshake, latch req_addr and go to LOOKUP.
  - IDLE with flush=1: clear every valid bit at that edge and stay in IDLE. Flush wins over a simultaneous request, which is not accepted. flush is ignored in every other state.
  - LOOKUP: compare tags across all ways at the latched index, with a hit requiring valid set. More than one matching way cannot occur.
    - Hit: latch the way's line into resp_data, set resp_hit=1, increment hit_count, go to RESP.
    - Miss: increment miss_count, drive mem_req_addr = {tag, index, OB'b0}, go to MISS_REQ.
  - MISS_REQ: mem_req_valid=1. mem_req_addr stays stable until mem_req_ready, then go to MISS_WAIT with mem_req_valid=0.
  - MISS_WAIT: wait for mem_resp_valid, then:
    - Victim way: the lowest-index invalid way at this index; if all ways are valid, the per-set round-robin pointer.
    - Write tag, valid and line into the victim way.
    - Advance the pointer (mod WAYS) only when it selected the victim.
    - Set resp_data = mem_resp_data and resp_hit=0, go to RESP.
    - mem_resp_valid is ignored in all other states.
  - RESP: resp_valid=1 for exactly one cycle, then go to IDLE. There is no response back-pressure; the consumer must take it.
- Counters saturate at 32'hFFFF_FFFF.
- Reset (reset=0 at an edge), from any state:
  - FSM returns to IDLE.
  - All valid bits and round-robin pointers clear.
  - Counters, resp_valid, resp_hit, resp_data, mem_req_valid and mem_req_addr all become 0.
  - Tag and data arrays need no reset.
  - An in-flight memory transaction is abandoned; its late response is ignored.

## Timing
- Request accepted at edge k → LOOKUP in cycle after k. Hit: resp_valid high in the cycle after edge k+2, for one cycle.
- Miss: mem_req_valid rises after edge k+2. Fill accepted at edge m → resp_valid high in the cycle after m for one cycle. req_ready returns high one cycle after that.
- Minimum request spacing is 3 edges; one outstanding request; no hit-under-miss.
- A fill is visible to lookups of the next request; a same-line re-request after the fill hits.
- All outputs are registered except req_ready.

## Structure
- Shared package cache_pkg holds:
  - state encoding (IDLE..RESP);
  - helper functions for OB/IB/tag widths and address slicing, reused by future data cache and write-back variants.
- Sub-module cache_way, instantiated WAYS times via generate:
  - valid/tag/line arrays of DEPTH entries;
  - combinational match output at an index;
  - line read port;
  - write port (index, tag, line);
  - invalidate-all input.
- Victim selection, round-robin pointers, counters and the FSM live in assoc_cache.

## Test plan
Defaults: WIDTH=128, DEPTH=4, WAYS=2 (OB=4, index=addr[5:4]).
- Cold miss then hit: reset, read 0x40 → mem_req_addr=0x40; fill 0xA5A5…A5 → resp_hit=0, data=0xA5…A5. Read 0x44 → resp_hit=1, same data, resp_valid after edge k+2, no mem_req_valid, hit_count=1, miss_count=1.
- Conflict eviction at index 0: fill 0x000 into way0 and 0x040 into way1. Read 0x080 → evicts way0 (pointer 0→1). Read 0x040 → hit; read 0x000 → miss.
- Stall handshakes: hold mem_req_ready=0 for 5 cycles → mem_req_valid stays 1 and mem_req_addr stays stable. Delay mem_resp_valid 7 cycles → resp_valid still a single pulse with correct data.
- Flush: flush=1 with req_valid=1 in IDLE → req_ready=0, no acceptance. The next read of a previously cached 0x40 → resp_hit=0.
- Reset in MISS_WAIT: reset=0 for one edge → all outputs and counters 0. A mem_resp_valid arriving afterwards produces no resp_valid. A subsequent read misses.
- Counter check: 3 misses then 2 hits → miss_count=3, hit_count=2. Preload counters near saturation (force) → counters stay at 32'hFFFF_FFFF.
